// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared definitions for the picoMIPS PC / instruction-fetch unit.
//   fetch_state_t      : FETCH (request in flight) / EXEC (instruction executing)
//   PSIZE_DEFAULT      : default PC / program-memory address width
//   ISIZE_DEFAULT      : default instruction width
//   OPC_W/OPC_MSB/LSB  : opcode field position inside an instruction word
// Opcode values themselves live in opcodes.sv.
package pc_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

    localparam int PSIZE_DEFAULT = 6;
    localparam int ISIZE_DEFAULT = 24;

    // Opcode occupies the top OPC_W bits of the instruction.
    localparam int OPC_W   = 6;
    localparam int OPC_MSB = ISIZE_DEFAULT - 1;
    localparam int OPC_LSB = ISIZE_DEFAULT - OPC_W;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selector.
//   pc_i      : current PC
//   field_i   : branch field, instr[Psize-1:0]
//   incr_i    : PC <= PC + 1
//   abs_i     : PC <= field (highest priority)
//   rel_i     : PC <= PC + sign-extended field
//   pc_next_o : selected next PC (PC unchanged when no control asserted)
module pc_next_calc #(
    parameter int Psize = 6
) (
    input  logic [Psize-1:0] pc_i,
    input  logic [Psize-1:0] field_i,
    input  logic             incr_i,
    input  logic             abs_i,
    input  logic             rel_i,
    output logic [Psize-1:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        if (abs_i) begin
            pc_next_o = field_i;
        end else if (rel_i) begin
            // The offset is as wide as the PC, so a plain modulo-2^Psize add
            // is identical to adding the sign-extended offset.
            pc_next_o = pc_i + field_i;
        end else if (incr_i) begin
            pc_next_o = pc_i + Psize'(1);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch unit for picoMIPS.
//   clk, nReset   : clock (rising edge), asynchronous active-low reset
//   imem_req      : fetch request, high in FETCH (forced low during reset)
//   imem_addr     : fetch address (= PCout)
//   imem_ack      : memory returns imem_rdata this cycle (FETCH only)
//   imem_rdata    : fetched instruction word
//   instr         : instruction register, to decoder/datapath
//   instr_valid   : high in EXEC
//   stall         : datapath hold; freezes EXEC
//   PCincr/PCabsbranch/PCrelbranch : decoder PC controls, used at EXEC exit
//   PCout         : current PC
//   icount        : retired-instruction counter (wraps)
//   dbg_state     : FSM state (0 = FETCH, 1 = EXEC) for observation
//
// Handshake: a fetch completes on the first rising edge where imem_req and
// imem_ack are both high; imem_ack may already be high in the first request
// cycle, and is ignored outside FETCH.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int Psize = PSIZE_DEFAULT,
    parameter int Isize = ISIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             nReset,
    output logic             imem_req,
    output logic [Psize-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [Isize-1:0] imem_rdata,
    output logic [Isize-1:0] instr,
    output logic             instr_valid,
    input  logic             stall,
    input  logic             PCincr,
    input  logic             PCabsbranch,
    input  logic             PCrelbranch,
    output logic [Psize-1:0] PCout,
    output logic [15:0]      icount,
    output logic             dbg_state
);

    fetch_state_t     state_q;
    logic [Psize-1:0] pc_q;
    logic [Psize-1:0] pc_d;
    logic [Isize-1:0] instr_q;
    logic [15:0]      icount_q;

    pc_next_calc #(
        .Psize (Psize)
    ) u_next (
        .pc_i      (pc_q),
        .field_i   (instr_q[Psize-1:0]),
        .incr_i    (PCincr),
        .abs_i     (PCabsbranch),
        .rel_i     (PCrelbranch),
        .pc_next_o (pc_d)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            instr_q  <= '0;
            icount_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc_q     <= pc_d;
                        icount_q <= icount_q + 16'd1;
                        state_q  <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // The reset value of state_q is FETCH, so the request is qualified with
    // nReset to keep it low while reset is held.
    assign imem_req    = nReset && (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign imem_addr   = pc_q;
    assign PCout       = pc_q;
    assign instr       = instr_q;
    assign icount      = icount_q;
    assign dbg_state   = state_q;

endmodule
